// File: rtl/multi_digit_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multi_digit_display_pkg
//  Description : Glyph set, 7-segment font and sizing helpers for the
//                multiplexed multi-digit display driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package multi_digit_display_pkg;

    // Display glyphs; G_0..G_F share their numeric value with the nibble.
    typedef enum logic [4:0] {
        G_0    = 5'd0,  G_1 = 5'd1,  G_2 = 5'd2,  G_3 = 5'd3,
        G_4    = 5'd4,  G_5 = 5'd5,  G_6 = 5'd6,  G_7 = 5'd7,
        G_8    = 5'd8,  G_9 = 5'd9,  G_A = 5'd10, G_B = 5'd11,
        G_C    = 5'd12, G_D = 5'd13, G_E = 5'd14, G_F = 5'd15,
        G_DASH = 5'd16,
        G_BLANK = 5'd17
    } glyph_t;

    // Active-low segment patterns {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    // Standard hex font, dp segment left off
    function automatic logic [7:0] seg_encode(input glyph_t g);
        logic [7:0] seg;
        case (g)
            G_0:     seg = 8'hC0;
            G_1:     seg = 8'hF9;
            G_2:     seg = 8'hA4;
            G_3:     seg = 8'hB0;
            G_4:     seg = 8'h99;
            G_5:     seg = 8'h92;
            G_6:     seg = 8'h82;
            G_7:     seg = 8'hF8;
            G_8:     seg = 8'h80;
            G_9:     seg = 8'h90;
            G_A:     seg = 8'h88;
            G_B:     seg = 8'h83;
            G_C:     seg = 8'hC6;
            G_D:     seg = 8'hA1;
            G_E:     seg = 8'h86;
            G_F:     seg = 8'h8E;
            G_DASH:  seg = SEG_DASH;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Largest value representable in 'digits' decimal digits
    function automatic logic [63:0] max_decimal(input int digits);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_digit_display_dd_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : dd_bin_to_bcd_seq
//  Description : Sequential double-dabble binary-to-BCD converter. The load
//                cycle performs the first iteration, so WIDTH cycles after
//                i_start the result is on o_bcd and o_done pulses. Only the
//                low DIGITS decimal digits are kept (value mod 10^DIGITS).
//  Revision    : 1.0 - initial release
// ============================================================================
module dd_bin_to_bcd_seq #(
    parameter int WIDTH  = 27,
    parameter int DIGITS = 8
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    input  logic                  i_start,
    input  logic [WIDTH-1:0]      i_value,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd
);

    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_CNT_W = $clog2(WIDTH + 1);

    logic [c_BCD_W-1:0] r_bcd;
    logic [WIDTH-1:0]   r_bin;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_done;
    logic [c_BCD_W-1:0] w_adj;

    // Add 3 to every BCD nibble that is 5 or more ahead of the shift
    function automatic logic [c_BCD_W-1:0] add3(input logic [c_BCD_W-1:0] b);
        logic [c_BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign w_adj = add3(r_bcd);

    // Load shifts in the value MSB; each further cycle is adjust-then-shift
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_bcd  <= '0;
            r_bin  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_start) begin
            r_bcd  <= {{(c_BCD_W-1){1'b0}}, i_value[WIDTH-1]};
            r_bin  <= i_value << 1;
            r_cnt  <= c_CNT_W'(WIDTH - 1);
            r_done <= (WIDTH == 1);
        end else if (r_cnt != '0) begin
            r_bcd  <= c_BCD_W'({w_adj, r_bin[WIDTH-1]});
            r_bin  <= r_bin << 1;
            r_cnt  <= r_cnt - c_CNT_W'(1);
            r_done <= (r_cnt == c_CNT_W'(1));
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_busy = (r_cnt != '0);
    assign o_done = r_done;
    assign o_bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/multi_digit_display.sv
`default_nettype none
// ============================================================================
//  Module      : multi_digit_display
//  Description : N-digit multiplexed 7-segment driver with on-chip
//                binary-to-BCD conversion, hex mode, leading-zero blanking,
//                live decimal points and overflow dashes.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_digit_display #(
    parameter int DIGITS      = 8,
    parameter int VALUE_WIDTH = 27,
    parameter int CLK_HZ      = 100_000_000,
    parameter int SCAN_HZ     = 1000
) (
    input  logic                   i_clk,
    input  logic                   i_resetn,
    input  logic [VALUE_WIDTH-1:0] i_value,
    input  logic                   i_hex,
    input  logic                   i_blank_lz,
    input  logic [DIGITS-1:0]      i_dp,
    output logic [7:0]             o_cathode,
    output logic [DIGITS-1:0]      o_anode,
    output logic                   o_busy
);
    import multi_digit_display_pkg::*;

    localparam int c_TICK_DIV = CLK_HZ / SCAN_HZ;
    localparam int c_TICK_W   = (c_TICK_DIV > 1) ? $clog2(c_TICK_DIV) : 1;
    localparam int c_IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(c_TICK_DIV - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0]   c_ONE_HOT0  = DIGITS'(1);
    localparam logic [63:0]         c_MAX_DEC   = max_decimal(DIGITS);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SHIFT  = 2'd1;
    localparam logic [1:0] c_ST_COMMIT = 2'd2;

    if (c_TICK_DIV < 2) begin : g_bad_tick_div
        $error("multi_digit_display: CLK_HZ/SCAN_HZ must be at least 2");
    end
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("multi_digit_display: DIGITS must be in 1..8");
    end

    logic [1:0]             r_state;
    logic                   r_force;
    logic                   r_busy;
    logic [VALUE_WIDTH-1:0] r_val;
    logic                   r_hex;
    logic                   r_blz;
    glyph_t                 r_buf [DIGITS];
    logic [c_TICK_W-1:0]    r_tick;
    logic [c_IDX_W-1:0]     r_idx;
    logic [DIGITS-1:0]      r_anode;
    logic [7:0]             r_cathode;

    logic                   w_change;
    logic                   w_start_dd;
    logic                   w_dd_busy;
    logic                   w_dd_done;
    logic [4*DIGITS-1:0]    w_bcd;
    logic                   w_ovf;
    logic [3:0]             w_hex_nib [DIGITS];
    logic [3:0]             w_nib     [DIGITS];
    glyph_t                 w_glyph   [DIGITS];
    logic                   w_nz_above;
    logic [DIGITS-1:0]      w_anode_sel;
    logic [7:0]             w_cath;

    assign w_change   = r_force || ({i_value, i_hex, i_blank_lz} != {r_val, r_hex, r_blz});
    assign w_start_dd = (r_state == c_ST_IDLE) && w_change && !i_hex;

    dd_bin_to_bcd_seq #(
        .WIDTH  (VALUE_WIDTH),
        .DIGITS (DIGITS)
    ) u_dd (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .i_start  (w_start_dd),
        .i_value  (i_value),
        .o_busy   (w_dd_busy),
        .o_done   (w_dd_done),
        .o_bcd    (w_bcd)
    );

    // Hex nibbles beyond the value width read as zero; nibbles beyond DIGITS are dropped
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        if (4*gi + 4 <= VALUE_WIDTH) begin : g_full
            assign w_hex_nib[gi] = r_val[4*gi +: 4];
        end else if (4*gi < VALUE_WIDTH) begin : g_part
            assign w_hex_nib[gi] = 4'(r_val[VALUE_WIDTH-1:4*gi]);
        end else begin : g_none
            assign w_hex_nib[gi] = 4'd0;
        end
        assign w_nib[gi] = r_hex ? w_hex_nib[gi] : w_bcd[4*gi +: 4];
    end

    assign w_ovf = !r_hex && (64'(r_val) > c_MAX_DEC);

    // Glyph selection, walking down from the top digit to find leading zeros
    always_comb begin
        w_nz_above = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (w_ovf) begin
                w_glyph[i] = G_DASH;
            end else if (r_blz && (i != 0) && !w_nz_above && (w_nib[i] == 4'd0)) begin
                w_glyph[i] = G_BLANK;
            end else begin
                w_glyph[i] = glyph_t'({1'b0, w_nib[i]});
            end
            if (w_nib[i] != 4'd0) begin
                w_nz_above = 1'b1;
            end
        end
    end

    // Conversion control: latch inputs, wait on the BCD core, commit glyphs
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state <= c_ST_IDLE;
            r_force <= 1'b1;
            r_busy  <= 1'b0;
            r_val   <= '0;
            r_hex   <= 1'b0;
            r_blz   <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                r_buf[i] <= G_BLANK;
            end
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_change) begin
                        r_val   <= i_value;
                        r_hex   <= i_hex;
                        r_blz   <= i_blank_lz;
                        r_busy  <= 1'b1;
                        r_state <= i_hex ? c_ST_COMMIT : c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    // done is the normal exit; an idle core also means the result is ready
                    if (w_dd_done || !w_dd_busy) begin
                        r_state <= c_ST_COMMIT;
                    end
                end
                c_ST_COMMIT: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        r_buf[i] <= w_glyph[i];
                    end
                    r_busy  <= 1'b0;
                    r_force <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign w_anode_sel = ~(c_ONE_HOT0 << r_idx);
    assign w_cath      = seg_encode(r_buf[r_idx]) & ~{i_dp[r_idx], 7'b0};

    // Scanner: anode and cathode move together on each tick wrap
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_tick    <= '0;
            r_idx     <= '0;
            r_anode   <= '1;
            r_cathode <= SEG_BLANK;
        end else if (r_tick == c_TICK_LAST) begin
            r_tick    <= '0;
            r_anode   <= w_anode_sel;
            r_cathode <= w_cath;
            r_idx     <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);
        end else begin
            r_tick <= r_tick + c_TICK_W'(1);
        end
    end

    assign o_anode   = r_anode;
    assign o_cathode = r_cathode;
    assign o_busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_multi_digit_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_digit_display
//  Description : Directed vector bench for multi_digit_display (4 digits,
//                16-bit value, 4-cycle scan step).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_digit_display;

    localparam int D    = 4;
    localparam int W    = 16;
    localparam int TICK = 4;

    logic           clk = 1'b0;
    logic           resetn;
    logic [W-1:0]   value;
    logic           hex;
    logic           blz;
    logic [D-1:0]   dp;
    logic [7:0]     cathode;
    logic [D-1:0]   anode;
    logic           busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [W-1:0]      value;
        logic              hex;
        logic              blz;
        logic [D-1:0]      dp;
        logic [D-1:0][7:0] exp;   // exp[0] = rightmost digit
    } vec_t;

    vec_t vecs [13];

    multi_digit_display #(
        .DIGITS      (D),
        .VALUE_WIDTH (W),
        .CLK_HZ      (4000),
        .SCAN_HZ     (1000)
    ) dut (
        .i_clk      (clk),
        .i_resetn   (resetn),
        .i_value    (value),
        .i_hex      (hex),
        .i_blank_lz (blz),
        .i_dp       (dp),
        .o_cathode  (cathode),
        .o_anode    (anode),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Wait (bounded) until the converter is idle
    task automatic wait_idle(input string name);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: busy never dropped, got 1, expected 0", name);
        end
    endtask

    // Number of consecutive negedges with busy high, starting at the next one
    task automatic count_busy(output int n);
        int guard;
        n = 0;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 200) begin
            n++;
            guard++;
            @(negedge clk);
        end
    endtask

    // Two full scan rounds; keep the last cathode seen for each anode
    task automatic capture(output logic [D-1:0][7:0] got);
        got = '0;
        repeat (2 * D * TICK) begin
            @(negedge clk);
            case (anode)
                4'b1110: got[0] = cathode;
                4'b1101: got[1] = cathode;
                4'b1011: got[2] = cathode;
                4'b0111: got[3] = cathode;
                default: ;
            endcase
        end
    endtask

    task automatic check_display(input string name, input logic [D-1:0][7:0] exp);
        logic [D-1:0][7:0] got;
        capture(got);
        for (int d = 0; d < D; d++) begin
            check($sformatf("%s digit%0d", name, d), 32'(got[d]), 32'(exp[d]));
        end
    endtask

    initial begin
        int n;
        int rises;
        logic prev;

        //            value     hex   blz   dp       {d3, d2, d1, d0}
        vecs[0]  = '{16'd1234,  1'b0, 1'b0, 4'b0000, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
        vecs[1]  = '{16'd7,     1'b0, 1'b1, 4'b0010, {8'hFF, 8'hFF, 8'h7F, 8'hF8}};
        vecs[2]  = '{16'd7,     1'b0, 1'b0, 4'b0010, {8'hC0, 8'hC0, 8'h40, 8'hF8}};
        vecs[3]  = '{16'd12345, 1'b0, 1'b0, 4'b0000, {8'hBF, 8'hBF, 8'hBF, 8'hBF}};
        vecs[4]  = '{16'd9999,  1'b0, 1'b0, 4'b0000, {8'h90, 8'h90, 8'h90, 8'h90}};
        vecs[5]  = '{16'hBEEF,  1'b1, 1'b0, 4'b0000, {8'h83, 8'h86, 8'h86, 8'h8E}};
        vecs[6]  = '{16'hBEEF,  1'b0, 1'b0, 4'b0000, {8'hBF, 8'hBF, 8'hBF, 8'hBF}};
        vecs[7]  = '{16'd0,     1'b0, 1'b1, 4'b0000, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
        vecs[8]  = '{16'h00A0,  1'b1, 1'b1, 4'b1000, {8'h7F, 8'hFF, 8'h88, 8'hC0}};
        vecs[9]  = '{16'd10000, 1'b0, 1'b0, 4'b0000, {8'hBF, 8'hBF, 8'hBF, 8'hBF}};
        vecs[10] = '{16'd1005,  1'b0, 1'b1, 4'b0001, {8'hF9, 8'hC0, 8'hC0, 8'h12}};
        vecs[11] = '{16'd3,     1'b0, 1'b0, 4'b1111, {8'h40, 8'h40, 8'h40, 8'h30}};
        vecs[12] = '{16'd5678,  1'b0, 1'b1, 4'b0000, {8'h92, 8'h82, 8'hF8, 8'h80}};

        // Reset state
        resetn = 1'b0;
        value  = 16'd1234;
        hex    = 1'b0;
        blz    = 1'b0;
        dp     = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset anode", 32'(anode), 32'hF);
        check("reset cathode", 32'(cathode), 32'hFF);

        // Forced first conversion: busy for VALUE_WIDTH+1 cycles
        resetn = 1'b1;
        count_busy(n);
        check("first conversion busy cycles", 32'(n), 32'd17);

        // Vector table
        for (int i = 0; i < 13; i++) begin
            value = vecs[i].value;
            hex   = vecs[i].hex;
            blz   = vecs[i].blz;
            dp    = vecs[i].dp;
            wait_idle($sformatf("vec%0d", i));
            check_display($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Hex conversion is a single busy cycle
        dp    = '0;
        blz   = 1'b0;
        hex   = 1'b1;
        value = 16'hC0DE;
        count_busy(n);
        check("hex busy cycles", 32'(n), 32'd1);
        check_display("hex C0DE", {8'hC6, 8'hC0, 8'hA1, 8'h86});

        // Decimal reconversion takes the full shift sequence
        hex   = 1'b0;
        value = 16'd42;
        count_busy(n);
        check("decimal busy cycles", 32'(n), 32'd17);

        // Changes while busy: one extra conversion, last value wins
        wait_idle("pre last-wins");
        value = 16'd1111;
        rises = 0;
        prev  = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (busy && !prev) rises++;
            prev = busy;
            if (c == 3) value = 16'd2222;
            if (c == 8) value = 16'd3333;
        end
        check("last-wins conversion count", 32'(rises), 32'd2);
        check_display("last-wins", {8'hB0, 8'hB0, 8'hB0, 8'hB0});

        // Reset during the 5th SHIFT cycle aborts the conversion
        value = 16'd4321;
        repeat (5) @(negedge clk);
        check("busy before abort", 32'(busy), 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        check("abort busy", 32'(busy), 32'd0);
        check("abort anode", 32'(anode), 32'hF);
        check("abort cathode", 32'(cathode), 32'hFF);
        resetn = 1'b1;
        count_busy(n);
        check("post-abort busy cycles", 32'(n), 32'd17);
        check_display("post-abort", {8'h99, 8'hB0, 8'hA4, 8'hF9});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
